// File: rtl/booth_product_accumulator.sv
// Sums COUNT signed products from the Booth multiplier per frame and hands the frame sum out
// over valid/ready. Define SATURATE_EN to clamp overflowing sums instead of wrapping them.
module booth_product_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned COUNT  = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_done,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              ovf,
    output logic              drop_err
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q, state_d;
    logic              done_q;
    logic              capture;
    logic              handshake;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum_raw;
    logic [ACC_W-1:0]  sum_next;
    logic              sum_ovf;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;

    assign capture   = prod_done & ~done_q;
    assign handshake = (state_q == StHold) & acc_ready;
    assign prod_ext  = ACC_W'($signed(prod_in));
    assign sum_raw   = acc_q + prod_ext;
    assign sum_ovf   = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                       (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    assign cnt_inc   = cnt_q + CntOne;

`ifdef SATURATE_EN
    localparam logic [ACC_W-1:0] MaxPos = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MinNeg = {1'b1, {(ACC_W-1){1'b0}}};

    // Overflow can only happen with equal operand signs, so the accumulator sign picks the rail.
    assign sum_next = sum_ovf ? (acc_q[ACC_W-1] ? MinNeg : MaxPos) : sum_raw;
`else
    assign sum_next = sum_raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (capture) state_d = (COUNT == 1) ? StHold : StAcc;
                end
                StAcc: begin
                    if (capture && (cnt_inc == CntMax)) state_d = StHold;
                end
                StHold: begin
                    if (handshake) begin
                        if (capture) state_d = (COUNT == 1) ? StHold : StAcc;
                        else         state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clear) begin
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            drop_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (capture) begin
                        acc_d = prod_ext;
                        cnt_d = CntOne;
                        ovf_d = 1'b0;
                    end
                end
                StAcc: begin
                    if (capture) begin
                        acc_d = sum_next;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | sum_ovf;
                    end
                end
                StHold: begin
                    if (handshake) begin
                        // A product landing on the handshake cycle opens the next frame.
                        acc_d = capture ? prod_ext : '0;
                        cnt_d = capture ? CntOne : '0;
                        ovf_d = 1'b0;
                    end else if (capture) begin
                        drop_d = 1'b1;
                    end
                end
                default: begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            done_q <= prod_done;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    always_comb begin
        acc_valid = (state_q == StHold);
        acc_out   = acc_q;
        cnt_out   = cnt_q;
        ovf       = ovf_q;
        drop_err  = drop_q;
    end

endmodule
